// File: rtl/sbus_pkg.sv
// Shared types, FSM encoding and default timing for the S-bus MOS memory
// controller. The word and request-mask types use big-endian bit numbering
// (bit 0 is the MSB), matching the PDP-10 S-bus documentation.
package sbus_pkg;

    typedef logic [0:35] word_t;
    typedef logic [0:3]  rq_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_ACCESS,
        ST_XFER,
        ST_GAP
    } sbus_state_e;

    localparam int DEF_ADR_W    = 22;
    localparam int DEF_DEPTH    = 2**18;
    localparam int DEF_ACC_CYC  = 44;
    localparam int DEF_WORD_CYC = 19;

    // Index of the first requested word at or after 'from'.
    // Bit 2 of the result is set when no further word is requested.
    function automatic logic [2:0] next_word(input rq_t rq, input logic [2:0] from);
        logic [2:0] res;
        res = 3'd4;
        for (int i = 3; i >= 0; i--) begin
            if ((3'(i) >= from) && rq[i]) begin
                res = 3'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sbus_rr_arbiter.sv
// Round-robin arbiter: picks the lowest requesting port at or after the
// rotating pointer and moves the pointer past the winner when the grant
// is taken.
module sbus_rr_arbiter #(
    parameter int NPORTS = 2,
    parameter int PW     = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NPORTS-1:0] req,
    input  logic              take,
    output logic [NPORTS-1:0] grant,
    output logic [PW-1:0]     grant_idx
);

    logic [PW-1:0] ptr;
    logic          found;
    int            scan;

    // Circular scan starting at the pointer; the first requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        scan      = 0;
        for (int k = 0; k < NPORTS; k++) begin
            scan = int'(ptr) + k;
            if (scan >= NPORTS) begin
                scan = scan - NPORTS;
            end
            if (!found && req[scan]) begin
                found       = 1'b1;
                grant[scan] = 1'b1;
                grant_idx   = PW'(scan);
            end
        end
    end

    // Advance the pointer to the port after the one just granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (take && found) begin
            ptr <= (grant_idx == PW'(NPORTS - 1)) ? '0 : grant_idx + PW'(1);
        end
    end

endmodule

// File: rtl/sbus_mos_memory_ctl.sv
// MF20-style MOS memory controller on the S-bus. Up to four ports post
// quad-word requests; one request is serviced at a time against a
// single-port word RAM with fixed access and inter-word timing. Requires
// ACC_CYC >= 2 and WORD_CYC >= 2.
module sbus_mos_memory_ctl
    import sbus_pkg::*;
#(
    parameter int NPORTS   = 2,
    parameter int ADR_W    = DEF_ADR_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ACC_CYC  = DEF_ACC_CYC,
    parameter int WORD_CYC = DEF_WORD_CYC
) (
    input  logic              clk,
    input  logic              CROBAR_N,
    input  logic [NPORTS-1:0] START,
    input  logic [NPORTS-1:0] WR,
    input  rq_t               RQ [NPORTS],
    input  logic [ADR_W-1:0]  ADR [NPORTS],
    input  word_t             DIN [NPORTS],
    output logic [NPORTS-1:0] ACKN,
    output logic [NPORTS-1:0] DATA_VALID,
    output word_t             D,
    output logic [NPORTS-1:0] NXM,
    output logic              BUSY
);

    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int MW = $clog2(DEPTH);
    localparam int CW = $clog2(((ACC_CYC > WORD_CYC) ? ACC_CYC : WORD_CYC) + 1);
    localparam logic [ADR_W:0] DEPTH_LIM = DEPTH[ADR_W:0];

    sbus_state_e       state;
    sbus_state_e       state_nx;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nx;
    logic [1:0]        idx;
    logic [1:0]        idx_nx;
    logic [PW-1:0]     cur;

    logic [NPORTS-1:0] start_q;
    logic [NPORTS-1:0] rise;
    logic [NPORTS-1:0] pend;
    logic [NPORTS-1:0] grant;
    logic [PW-1:0]     grant_idx;
    logic              take;

    logic [NPORTS-1:0] wr_l;
    rq_t               rq_l  [NPORTS];
    logic [ADR_W-1:0]  adr_l [NPORTS];

    logic              cur_wr;
    rq_t               cur_rq;
    logic [ADR_W-1:0]  cur_adr;
    logic              cur_nxm;
    logic [2:0]        first_w;
    logic [2:0]        next_w;
    logic [MW-1:0]     mem_idx;
    logic [NPORTS-1:0] cur_oh;

    word_t mem [DEPTH];

    assign rise = START & ~start_q;
    assign take = (state == ST_IDLE);

    sbus_rr_arbiter #(
        .NPORTS(NPORTS),
        .PW    (PW)
    ) u_arb (
        .clk      (clk),
        .rst_n    (CROBAR_N),
        .req      (pend),
        .take     (take),
        .grant    (grant),
        .grant_idx(grant_idx)
    );

    // Per-port START edge capture: a fresh edge latches the request unless
    // the port already has one pending or is the one being serviced.
    always_ff @(posedge clk or negedge CROBAR_N) begin
        if (!CROBAR_N) begin
            start_q <= '0;
            pend    <= '0;
            wr_l    <= '0;
            for (int p = 0; p < NPORTS; p++) begin
                rq_l[p]  <= '0;
                adr_l[p] <= '0;
            end
        end else begin
            start_q <= START;
            for (int p = 0; p < NPORTS; p++) begin
                if (take && grant[p]) begin
                    pend[p] <= 1'b0;
                end else if (rise[p] && !pend[p] && !(BUSY && (cur == PW'(p)))) begin
                    pend[p]  <= 1'b1;
                    wr_l[p]  <= WR[p];
                    rq_l[p]  <= RQ[p];
                    adr_l[p] <= ADR[p];
                end
            end
        end
    end

    assign cur_wr  = wr_l[cur];
    assign cur_rq  = rq_l[cur];
    assign cur_adr = adr_l[cur];
    assign cur_nxm = ({1'b0, cur_adr} >= DEPTH_LIM);
    assign first_w = next_word(cur_rq, 3'd0);
    assign next_w  = next_word(cur_rq, {1'b0, idx} + 3'd1);
    // The word offset wraps inside the quad and never carries into bit 2.
    assign mem_idx = {cur_adr[MW-1:2], cur_adr[1:0] + idx};

    // State, timing counter, word index and the port being serviced.
    always_ff @(posedge clk or negedge CROBAR_N) begin
        if (!CROBAR_N) begin
            state <= ST_IDLE;
            cnt   <= '0;
            idx   <= '0;
            cur   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
            if (take && (|pend)) begin
                cur <= grant_idx;
            end
        end
    end

    // Sequencing: accept, wait out the access time, then one word per
    // XFER with a fixed gap; unrequested words are skipped for free.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        case (state)
            ST_IDLE: begin
                if (|pend) begin
                    state_nx = ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                if (cur_nxm || first_w[2]) begin
                    state_nx = ST_IDLE;
                end else begin
                    idx_nx   = first_w[1:0];
                    cnt_nx   = CW'(ACC_CYC - 2);
                    state_nx = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt == '0) begin
                    state_nx = ST_XFER;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            ST_XFER: begin
                if (next_w[2]) begin
                    state_nx = ST_IDLE;
                end else begin
                    idx_nx   = next_w[1:0];
                    cnt_nx   = CW'(WORD_CYC - 2);
                    state_nx = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt == '0) begin
                    state_nx = ST_XFER;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // RAM write port: the word on DIN is stored in the DATA_VALID cycle.
    always_ff @(posedge clk) begin
        if ((state == ST_XFER) && cur_wr) begin
            mem[mem_idx] <= DIN[cur];
        end
    end

    // Read data is fetched the cycle before XFER and held until the next word.
    always_ff @(posedge clk or negedge CROBAR_N) begin
        if (!CROBAR_N) begin
            D <= '0;
        end else if ((state_nx == ST_XFER) && !cur_wr) begin
            D <= mem[mem_idx];
        end
    end

    // Port strobes are decoded from the state so reset clears them at once.
    always_comb begin
        cur_oh     = NPORTS'(1) << cur;
        ACKN       = (state == ST_ACCEPT) ? cur_oh : '0;
        NXM        = ((state == ST_ACCEPT) && cur_nxm) ? cur_oh : '0;
        DATA_VALID = (state == ST_XFER) ? cur_oh : '0;
        BUSY       = (state != ST_IDLE);
    end

endmodule

// File: tb/tb_sbus_mos_memory_ctl.sv
// Self-checking bench for the S-bus MOS memory controller. Requests are
// checked against a transaction-level model: a sparse word memory, the
// round-robin service order and the fixed DATA_VALID schedule.
module tb_sbus_mos_memory_ctl;
    import sbus_pkg::*;

    localparam int NPORTS   = 2;
    localparam int ADR_W    = 22;
    localparam int DEPTH    = 2**18;
    localparam int ACC_CYC  = 44;
    localparam int WORD_CYC = 19;

    logic              clk = 1'b0;
    logic              CROBAR_N;
    logic [NPORTS-1:0] START;
    logic [NPORTS-1:0] WR;
    rq_t               RQ  [NPORTS];
    logic [ADR_W-1:0]  ADR [NPORTS];
    word_t             DIN [NPORTS];
    logic [NPORTS-1:0] ACKN;
    logic [NPORTS-1:0] DATA_VALID;
    word_t             D;
    logic [NPORTS-1:0] NXM;
    logic              BUSY;

    int errors = 0;
    int checks = 0;

    bit    req_wr   [NPORTS];
    rq_t   req_rq   [NPORTS];
    int    req_adr  [NPORTS];
    word_t req_data [NPORTS][4];

    word_t model_mem [int];
    int    rr_ptr = 0;

    sbus_mos_memory_ctl #(
        .NPORTS  (NPORTS),
        .ADR_W   (ADR_W),
        .DEPTH   (DEPTH),
        .ACC_CYC (ACC_CYC),
        .WORD_CYC(WORD_CYC)
    ) dut (
        .clk       (clk),
        .CROBAR_N  (CROBAR_N),
        .START     (START),
        .WR        (WR),
        .RQ        (RQ),
        .ADR       (ADR),
        .DIN       (DIN),
        .ACKN      (ACKN),
        .DATA_VALID(DATA_VALID),
        .D         (D),
        .NXM       (NXM),
        .BUSY      (BUSY)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic word_t rand_word();
        return {4'($urandom_range(0, 15)), 32'($urandom)};
    endfunction

    // Word i of a request lives in the same quad, offset wrapping mod 4.
    function automatic int word_addr(input int adr, input int i);
        return (adr & ~3) | ((adr + i) & 3);
    endfunction

    task automatic set_req(input int p, input bit wr, input rq_t rq, input int adr);
        req_wr[p]  = wr;
        req_rq[p]  = rq;
        req_adr[p] = adr;
        for (int i = 0; i < 4; i++) begin
            req_data[p][i] = rand_word();
        end
    endtask

    // Issue the described requests on the ports in 'mask' in the same clock
    // and watch the bus; abort_at > 0 pulls reset after that many words.
    task automatic apply_stimulus(input logic [NPORTS-1:0] mask, input int abort_at);
        int    nexp    [NPORTS];
        int    widx    [NPORTS][4];
        int    dv_cnt  [NPORTS];
        int    ack_cyc [NPORTS];
        bit    acked   [NPORTS];
        bit    nxm_exp [NPORTS];
        int    order[$];
        int    exp_order[$];
        int    win;
        int    total_dv;
        int    abort_due;
        int    release_at;
        bit    aborted;
        bit    d_hold_chk;
        word_t d_exp;
        int    a;
        int    k;
        int    q;

        abort_due  = -1;
        release_at = -1;
        aborted    = 1'b0;
        d_hold_chk = 1'b0;
        d_exp      = '0;
        for (int p = 0; p < NPORTS; p++) begin
            nexp[p]    = 0;
            dv_cnt[p]  = 0;
            ack_cyc[p] = 0;
            acked[p]   = 1'b0;
            nxm_exp[p] = 1'b0;
            for (int i = 0; i < 4; i++) widx[p][i] = 0;
            if (mask[p]) begin
                nxm_exp[p] = (req_adr[p] >= DEPTH);
                if (!nxm_exp[p]) begin
                    for (int i = 0; i < 4; i++) begin
                        if (req_rq[p][i]) begin
                            widx[p][nexp[p]] = i;
                            nexp[p]++;
                        end
                    end
                end
            end
        end
        for (int j = 0; j < NPORTS; j++) begin
            q = (rr_ptr + j) % NPORTS;
            if (mask[q]) exp_order.push_back(q);
        end
        if (exp_order.size() > 0) rr_ptr = (exp_order[exp_order.size() - 1] + 1) % NPORTS;

        win = $countones(mask) * (ACC_CYC + 4 * WORD_CYC + 8);
        @(negedge clk);
        for (int p = 0; p < NPORTS; p++) begin
            if (mask[p]) begin
                WR[p]    = req_wr[p];
                RQ[p]    = req_rq[p];
                ADR[p]   = ADR_W'(req_adr[p]);
                START[p] = 1'b1;
            end
        end

        for (int c = 1; c <= win; c++) begin
            @(negedge clk);
            for (int p = 0; p < NPORTS; p++) begin
                if (mask[p] && dv_cnt[p] < nexp[p]) DIN[p] = req_data[p][widx[p][dv_cnt[p]]];
            end
            if (d_hold_chk) begin
                check_output("d_hold", 64'(D), 64'(d_exp));
                d_hold_chk = 1'b0;
            end
            total_dv = 0;
            for (int p = 0; p < NPORTS; p++) begin
                if (ACKN[p]) begin
                    if (mask[p] && !acked[p]) begin
                        acked[p]   = 1'b1;
                        ack_cyc[p] = c;
                        order.push_back(p);
                        START[p]   = 1'b0;
                        check_output($sformatf("nxm_at_ackn p%0d", p), 64'(NXM[p]), 64'(nxm_exp[p]));
                        check_output("busy_at_ackn", 64'(BUSY), 64'd1);
                    end else begin
                        check_output($sformatf("ackn_spurious p%0d", p), 64'(ACKN[p]), 64'd0);
                    end
                end else if (NXM[p]) begin
                    check_output($sformatf("nxm_without_ackn p%0d", p), 64'(NXM[p]), 64'd0);
                end
                if (DATA_VALID[p]) begin
                    k = dv_cnt[p];
                    if (!mask[p] || !acked[p] || k >= nexp[p]) begin
                        check_output($sformatf("dv_extra p%0d", p), 64'(DATA_VALID[p]), 64'd0);
                    end else begin
                        check_output($sformatf("dv_time p%0d w%0d", p, k), 64'(c),
                                     64'(ack_cyc[p] + ACC_CYC + k * WORD_CYC));
                        a = word_addr(req_adr[p], widx[p][k]);
                        if (req_wr[p]) begin
                            model_mem[a] = req_data[p][widx[p][k]];
                        end else begin
                            d_exp = model_mem.exists(a) ? model_mem[a] : word_t'(0);
                            check_output($sformatf("rd_data p%0d adr %0d", p, a), 64'(D), 64'(d_exp));
                            d_hold_chk = 1'b1;
                        end
                        dv_cnt[p]++;
                    end
                end
                total_dv += dv_cnt[p];
            end
            if (abort_at > 0 && !aborted) begin
                if (abort_due < 0 && total_dv == abort_at) abort_due = c + 3;
                if (c == abort_due) begin
                    CROBAR_N = 1'b0;
                    #1;
                    check_output("abort_ackn", 64'(ACKN), 64'd0);
                    check_output("abort_dv", 64'(DATA_VALID), 64'd0);
                    check_output("abort_nxm", 64'(NXM), 64'd0);
                    check_output("abort_busy", 64'(BUSY), 64'd0);
                    check_output("abort_d", 64'(D), 64'd0);
                    aborted    = 1'b1;
                    release_at = c + 3;
                    for (int p = 0; p < NPORTS; p++) nexp[p] = dv_cnt[p];
                end
            end
            if (aborted && c == release_at) CROBAR_N = 1'b1;
        end

        for (int p = 0; p < NPORTS; p++) begin
            if (mask[p]) begin
                START[p] = 1'b0;
                check_output($sformatf("ackn_seen p%0d", p), 64'(acked[p]), 64'd1);
                check_output($sformatf("dv_count p%0d", p), 64'(dv_cnt[p]), 64'(nexp[p]));
            end
        end
        for (int i = 0; i < exp_order.size(); i++) begin
            check_output($sformatf("grant_order %0d", i),
                         64'((order.size() > i) ? order[i] : -1), 64'(exp_order[i]));
        end
        check_output("busy_idle", 64'(BUSY), 64'd0);
        if (aborted) rr_ptr = 0;
    endtask

    initial begin
        CROBAR_N = 1'b0;
        START    = '0;
        WR       = '0;
        for (int p = 0; p < NPORTS; p++) begin
            RQ[p]  = '0;
            ADR[p] = '0;
            DIN[p] = '0;
        end
        repeat (3) @(negedge clk);
        check_output("rst_ackn", 64'(ACKN), 64'd0);
        check_output("rst_dv", 64'(DATA_VALID), 64'd0);
        check_output("rst_nxm", 64'(NXM), 64'd0);
        check_output("rst_busy", 64'(BUSY), 64'd0);
        check_output("rst_d", 64'(D), 64'd0);
        CROBAR_N = 1'b1;
        repeat (2) @(negedge clk);
        check_output("idle_busy", 64'(BUSY), 64'd0);

        $display("[TB] preload and quad read");
        set_req(0, 1'b1, 4'b1111, 100);
        req_data[0][0] = 36'd1;
        req_data[0][1] = 36'd2;
        req_data[0][2] = 36'd3;
        req_data[0][3] = 36'd4;
        apply_stimulus(2'b01, 0);
        set_req(0, 1'b1, 4'b1000, 104);
        apply_stimulus(2'b01, 0);
        set_req(0, 1'b0, 4'b1111, 100);
        apply_stimulus(2'b01, 0);

        $display("[TB] quad wrap");
        set_req(0, 1'b0, 4'b1111, 102);
        apply_stimulus(2'b01, 0);
        set_req(1, 1'b1, 4'b1111, 102);
        apply_stimulus(2'b10, 0);
        set_req(1, 1'b0, 4'b1000, 104);
        apply_stimulus(2'b10, 0);

        $display("[TB] sparse mask");
        set_req(0, 1'b1, 4'b1111, 200);
        apply_stimulus(2'b01, 0);
        set_req(0, 1'b0, 4'b1010, 200);
        apply_stimulus(2'b01, 0);

        $display("[TB] write then read");
        set_req(0, 1'b1, 4'b1000, 300);
        req_data[0][0] = 36'o123456654321;
        apply_stimulus(2'b01, 0);
        set_req(1, 1'b0, 4'b1000, 300);
        apply_stimulus(2'b10, 0);

        $display("[TB] contention");
        set_req(0, 1'b0, 4'b1100, 100);
        set_req(1, 1'b0, 4'b0011, 200);
        apply_stimulus(2'b11, 0);
        set_req(0, 1'b0, 4'b1000, 300);
        apply_stimulus(2'b01, 0);
        set_req(0, 1'b0, 4'b1100, 100);
        set_req(1, 1'b0, 4'b0011, 200);
        apply_stimulus(2'b11, 0);

        $display("[TB] address limit and empty mask");
        set_req(0, 1'b0, 4'b1111, DEPTH);
        apply_stimulus(2'b01, 0);
        set_req(1, 1'b1, 4'b1000, DEPTH - 1);
        apply_stimulus(2'b10, 0);
        set_req(1, 1'b0, 4'b1000, DEPTH - 1);
        apply_stimulus(2'b10, 0);
        set_req(1, 1'b0, 4'b0000, 100);
        apply_stimulus(2'b10, 0);

        $display("[TB] randomized traffic");
        for (int qd = 0; qd < 4; qd++) begin
            set_req(qd % 2, 1'b1, 4'b1111, 400 + 4 * qd);
            apply_stimulus((qd % 2 == 0) ? 2'b01 : 2'b10, 0);
        end
        for (int n = 0; n < 16; n++) begin
            logic [NPORTS-1:0] m;
            m = 2'($urandom_range(1, 3));
            for (int p = 0; p < NPORTS; p++) begin
                set_req(p, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                        400 + $urandom_range(0, 15));
            end
            apply_stimulus(m, 0);
        end

        $display("[TB] reset during requests");
        set_req(0, 1'b1, 4'b1111, 400);
        apply_stimulus(2'b01, 2);
        set_req(0, 1'b0, 4'b1111, 400);
        apply_stimulus(2'b01, 0);
        set_req(1, 1'b0, 4'b1111, 404);
        apply_stimulus(2'b10, 1);
        set_req(0, 1'b0, 4'b1111, 404);
        apply_stimulus(2'b01, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
